// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one TX FIFO write port among NREQ producers.
// A grant ends on req_last, after MAX_BURST words, or after IDLE_TIMEOUT idle cycles.
module fifo_wr_arbiter #(
    parameter int NREQ         = 4,
    parameter int DWIDTH       = 16,
    parameter int MAX_BURST    = 8,
    parameter int IDLE_TIMEOUT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*DWIDTH-1:0]      req_data,
    input  logic [NREQ-1:0]             req_last,
    output logic [NREQ-1:0]             req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DWIDTH-1:0]           fifo_wdata,
    output logic [$clog2(NREQ)-1:0]     grant_id,
    output logic                        busy
);

    // Handshake: a word moves when req_valid[i] & req_ready[i] in the same cycle;
    // only the granted requester ever sees ready, and only while the FIFO is not full.

    localparam int GW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BW-1:0] MAX_B  = BW'(MAX_BURST);
    localparam logic [IW-1:0] IDLE_T = IW'(IDLE_TIMEOUT);
    localparam logic [GW-1:0] LAST_ID = GW'(NREQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_next;
    logic [GW-1:0]  rr_ptr, rr_next;
    logic [GW-1:0]  grant_next, pick, release_ptr;
    logic [BW-1:0]  burst_cnt, burst_next, burst_inc;
    logic [IW-1:0]  idle_cnt, idle_next, idle_inc;
    logic           active, accept;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        logic          found;
        int            idx;
        logic [GW-1:0] idx_g;
        found = 1'b0;
        pick  = rr_ptr;
        idx   = 0;
        idx_g = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_g = GW'(idx);
            if (!found && req_valid[idx_g]) begin
                found = 1'b1;
                pick  = idx_g;
            end
        end
    end

    assign release_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    assign burst_inc   = burst_cnt + 1'b1;
    assign idle_inc    = idle_cnt + 1'b1;

    // Reset gates the outputs in the same cycle, before the state register clears.
    assign active     = (state == GRANT) && !reset;
    assign accept     = active && req_valid[grant_id] && !fifo_full;
    assign fifo_wr    = accept;
    assign busy       = active;
    assign fifo_wdata = req_data[grant_id*DWIDTH +: DWIDTH];

    always_comb begin
        req_ready = '0;
        if (active) req_ready[grant_id] = ~fifo_full;
    end

    always_comb begin
        state_next = state;
        rr_next    = rr_ptr;
        grant_next = grant_id;
        burst_next = burst_cnt;
        idle_next  = idle_cnt;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_next = GRANT;
                    grant_next = pick;
                    burst_next = '0;
                    idle_next  = '0;
                end
            end
            GRANT: begin
                // A full FIFO freezes every counter; the grant is held as long as it lasts.
                if (!fifo_full) begin
                    if (req_valid[grant_id]) begin
                        burst_next = burst_inc;
                        idle_next  = '0;
                        if (req_last[grant_id] || (burst_inc == MAX_B)) begin
                            state_next = IDLE;
                            rr_next    = release_ptr;
                        end
                    end else begin
                        idle_next = idle_inc;
                        if (idle_inc == IDLE_T) begin
                            state_next = IDLE;
                            rr_next    = release_ptr;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_next;
            grant_id  <= grant_next;
            burst_cnt <= burst_next;
            idle_cnt  <= idle_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer model, expected-word queue and
// immediate assertions at each check point.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [63:0] req_data;
    logic        fifo_full, fifo_wr, busy;
    logic [15:0] fifo_wdata;
    logic [1:0]  grant_id;

    int errors = 0;
    int checks = 0;
    int len[4], last_at[4], sent[4];
    logic rst_cfg, full_cfg;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(4), .DWIDTH(16), .MAX_BURST(8), .IDLE_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .grant_id(grant_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, then check the combinational outputs.
    task automatic cycle();
        logic [31:0] exp_w;
        @(negedge clk);
        reset     = rst_cfg;
        fifo_full = full_cfg;
        for (int i = 0; i < 4; i++) begin
            req_valid[i]         = (sent[i] < len[i]);
            req_data[i*16 +: 16] = 16'((i << 12) | sent[i]);
            req_last[i]          = (sent[i] + 1 == last_at[i]);
        end
        #1;
        chk("ready_onehot0", {31'd0, $onehot0(req_ready)}, 32'd1);
        chk("wr_while_full", {31'd0, fifo_wr & fifo_full}, 32'd0);
        if (fifo_wr) begin
            exp_w = (exp_q.size() > 0) ? {16'd0, exp_q.pop_front()} : 32'hDEADBEEF;
            chk("fifo_word", {16'd0, fifo_wdata}, exp_w);
        end
        for (int i = 0; i < 4; i++)
            if (req_valid[i] && req_ready[i]) sent[i]++;
    endtask

    task automatic do_reset();
        rst_cfg  = 1'b1;
        full_cfg = 1'b0;
        for (int i = 0; i < 4; i++) begin
            len[i] = 0; last_at[i] = 0; sent[i] = 0;
        end
        exp_q.delete();
        cycle();
        cycle();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr", {31'd0, fifo_wr}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        rst_cfg = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fifo_full = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        do_reset();

        // T1: single 3-word packet from requester 2
        len[2] = 3; last_at[2] = 3;
        exp_q = '{16'h2000, 16'h2001, 16'h2002};
        cycle();
        chk("t1_bubble_busy", {31'd0, busy}, 32'd0);
        chk("t1_reset_grant_id", {30'd0, grant_id}, 32'd0);
        chk("t1_bubble_wr", {31'd0, fifo_wr}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t1_grant_id", {30'd0, grant_id}, 32'd2);
            chk("t1_wr", {31'd0, fifo_wr}, 32'd1);
            chk("t1_ready", {28'd0, req_ready}, 32'h4);
        end
        cycle();
        chk("t1_release_busy", {31'd0, busy}, 32'd0);
        chk("t1_hold_grant_id", {30'd0, grant_id}, 32'd2);
        chk("t1_drained", exp_q.size(), 32'd0);

        // T1b: rr_ptr is now 3, so requester 3 beats requester 0
        len[0] = 1; last_at[0] = 1; len[3] = 1; last_at[3] = 1;
        exp_q = '{16'h3000, 16'h0000};
        cycle();
        chk("t1b_bubble_busy", {31'd0, busy}, 32'd0);
        cycle();
        chk("t1b_first_grant", {30'd0, grant_id}, 32'd3);
        chk("t1b_first_wr", {31'd0, fifo_wr}, 32'd1);
        cycle();
        chk("t1b_bubble2_busy", {31'd0, busy}, 32'd0);
        cycle();
        chk("t1b_second_grant", {30'd0, grant_id}, 32'd0);
        chk("t1b_second_wr", {31'd0, fifo_wr}, 32'd1);
        cycle();
        chk("t1b_idle_busy", {31'd0, busy}, 32'd0);
        chk("t1b_drained", exp_q.size(), 32'd0);

        // T2: all four valid, no last -> 8-word bursts in order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) len[i] = 16;
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < 8; k++)
                exp_q.push_back(16'(((b % 4) << 12) | ((b / 4) * 8 + k)));
        for (int b = 0; b < 5; b++) begin
            cycle();
            chk("t2_bubble_busy", {31'd0, busy}, 32'd0);
            chk("t2_bubble_wr", {31'd0, fifo_wr}, 32'd0);
            for (int k = 0; k < 8; k++) begin
                cycle();
                chk("t2_grant_id", {30'd0, grant_id}, 32'(b % 4));
                chk("t2_wr", {31'd0, fifo_wr}, 32'd1);
            end
        end
        cycle();
        chk("t2_final_bubble", {31'd0, busy}, 32'd0);
        chk("t2_drained", exp_q.size(), 32'd0);

        // T3: requester 1, FIFO full for 5 cycles after word 3
        do_reset();
        len[1] = 8;
        for (int k = 0; k < 8; k++) exp_q.push_back(16'h1000 | 16'(k));
        cycle();
        chk("t3_bubble_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t3_pre_wr", {31'd0, fifo_wr}, 32'd1);
        end
        full_cfg = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t3_stall_wr", {31'd0, fifo_wr}, 32'd0);
            chk("t3_stall_ready", {28'd0, req_ready}, 32'd0);
            chk("t3_stall_busy", {31'd0, busy}, 32'd1);
            chk("t3_stall_grant", {30'd0, grant_id}, 32'd1);
        end
        full_cfg = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t3_post_wr", {31'd0, fifo_wr}, 32'd1);
        end
        cycle();
        chk("t3_release_busy", {31'd0, busy}, 32'd0);
        chk("t3_drained", exp_q.size(), 32'd0);

        // T4: requester 0 sends 2 words then idles; timeout after 4 cycles, then requester 3
        do_reset();
        len[0] = 2; len[3] = 1; last_at[3] = 1;
        exp_q = '{16'h0000, 16'h0001, 16'h3000};
        cycle();
        chk("t4_bubble_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("t4_grant0", {30'd0, grant_id}, 32'd0);
            chk("t4_wr", {31'd0, fifo_wr}, 32'd1);
        end
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t4_idle_busy", {31'd0, busy}, 32'd1);
            chk("t4_idle_wr", {31'd0, fifo_wr}, 32'd0);
            chk("t4_idle_ready", {28'd0, req_ready}, 32'h1);
        end
        cycle();
        chk("t4_timeout_release", {31'd0, busy}, 32'd0);
        cycle();
        chk("t4_next_grant", {30'd0, grant_id}, 32'd3);
        chk("t4_next_wr", {31'd0, fifo_wr}, 32'd1);
        cycle();
        chk("t4_end_busy", {31'd0, busy}, 32'd0);
        chk("t4_drained", exp_q.size(), 32'd0);

        // T5: reset on the 3rd word of requester 2's burst (rr_ptr is 2 at that time)
        do_reset();
        len[1] = 1; last_at[1] = 1; len[2] = 8;
        exp_q = '{16'h1000, 16'h2000, 16'h2001};
        cycle();
        cycle();
        chk("t5_grant1", {30'd0, grant_id}, 32'd1);
        cycle();
        cycle();
        chk("t5_grant2", {30'd0, grant_id}, 32'd2);
        chk("t5_w1", {31'd0, fifo_wr}, 32'd1);
        cycle();
        chk("t5_w2", {31'd0, fifo_wr}, 32'd1);
        rst_cfg = 1'b1;
        cycle();
        chk("t5_rst_wr", {31'd0, fifo_wr}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_ready", {28'd0, req_ready}, 32'd0);
        rst_cfg = 1'b0;
        len[0] = 1; last_at[0] = 1;
        exp_q.push_back(16'h0000);
        for (int k = 2; k < 8; k++) exp_q.push_back(16'h2000 | 16'(k));
        cycle();
        chk("t5_after_busy", {31'd0, busy}, 32'd0);
        chk("t5_after_grant_id", {30'd0, grant_id}, 32'd0);
        cycle();
        chk("t5_restart_grant0", {30'd0, grant_id}, 32'd0);
        chk("t5_restart_wr", {31'd0, fifo_wr}, 32'd1);
        cycle();
        chk("t5_bubble_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("t5_resume_grant2", {30'd0, grant_id}, 32'd2);
            chk("t5_resume_wr", {31'd0, fifo_wr}, 32'd1);
        end
        chk("t5_drained", exp_q.size(), 32'd0);

        // T6: word 8 also carries last -> exactly one release
        do_reset();
        len[0] = 8; last_at[0] = 8; len[1] = 1; last_at[1] = 1;
        for (int k = 0; k < 8; k++) exp_q.push_back(16'(k));
        exp_q.push_back(16'h1000);
        cycle();
        chk("t6_bubble_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("t6_grant0", {30'd0, grant_id}, 32'd0);
            chk("t6_wr", {31'd0, fifo_wr}, 32'd1);
        end
        cycle();
        chk("t6_single_bubble", {31'd0, busy}, 32'd0);
        cycle();
        chk("t6_grant1", {30'd0, grant_id}, 32'd1);
        chk("t6_grant1_wr", {31'd0, fifo_wr}, 32'd1);
        cycle();
        chk("t6_end_busy", {31'd0, busy}, 32'd0);
        cycle();
        chk("t6_no_extra_grant", {31'd0, busy}, 32'd0);
        chk("t6_no_extra_wr", {31'd0, fifo_wr}, 32'd0);
        chk("t6_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
